// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default
// widths and the byte-to-word address shift.
package dm_arbiter_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select between the CPU (m0) and DMA (m1) masters.
// Build option: DM_ARB_RR_EN selects round-robin tie breaking; without it
// m0 always wins a simultaneous request.
module dm_arb_pick (
    input  logic m0_req_i,
    input  logic m1_req_i,
    input  logic prio_i,    // master that wins a tie under round-robin (0=m0, 1=m1)
    output logic any_o,
    output logic win_o      // 0 = m0 wins, 1 = m1 wins
);

`ifndef DM_ARB_RR_EN
    // Fixed priority ignores the pointer.
    logic unused_prio;
    assign unused_prio = prio_i;
`endif

    // Pick the winner; a tie is the only case where the policy matters.
    always_comb begin
        any_o = m0_req_i | m1_req_i;
        win_o = 1'b0;
        if (m0_req_i && m1_req_i) begin
`ifdef DM_ARB_RR_EN
            win_o = prio_i;
`else
            win_o = 1'b0;
`endif
        end else if (m1_req_i) begin
            win_o = 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of the single data memory. Converts byte
// addresses to word addresses and sequences each access IDLE -> ISSUE
// (-> RDWAIT for reads). Build option: DM_ARB_RR_EN (round-robin ties).
//
// Handshake: a master raises mX_req with stable we/addr/wdata and holds it
// until mX_gnt pulses; requests are sampled only in IDLE. Grant comes one
// cycle after the sample together with the DM strobes (or with mX_err for a
// misaligned address, in which case no DM access happens). A read returns
// mX_rvalid with rdata one cycle after the grant.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              DM_enable,
    output logic              DM_read,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out,
    output logic [1:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;     // misaligned grant pulse this cycle
    logic              prio_q, prio_d;   // round-robin: who wins the next tie
    logic [DATA_W-1:0] rdata_q, rdata_d; // last returned read word

    logic              pick_any, pick_win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              st_issue, st_rdwait;

    dm_arb_pick u_pick (
        .m0_req_i (m0_req),
        .m1_req_i (m1_req),
        .prio_i   (prio_q),
        .any_o    (pick_any),
        .win_o    (pick_win)
    );

    assign sel_we    = pick_win ? m1_we    : m0_we;
    assign sel_addr  = pick_win ? m1_addr  : m0_addr;
    assign sel_wdata = pick_win ? m1_wdata : m0_wdata;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, one issue cycle, one read-return cycle.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        prio_d  = prio_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                // The err pulse cycle still sees the granted master's held
                // req, so sampling is skipped there to avoid a double grant.
                if (!err_q && pick_any) begin
                    win_d   = pick_win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    prio_d  = ~pick_win;
                    if (sel_addr[WORD_SHIFT-1:0] == '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                rdata_d = DM_out;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state and captured request fields.
    always_comb begin
        st_issue    = (state_q == ST_ISSUE);
        st_rdwait   = (state_q == ST_RDWAIT);
        m0_gnt      = (st_issue | err_q) & ~win_q;
        m1_gnt      = (st_issue | err_q) &  win_q;
        m0_err      = err_q & ~win_q;
        m1_err      = err_q &  win_q;
        m0_rvalid   = st_rdwait & ~win_q;
        m1_rvalid   = st_rdwait &  win_q;
        rdata       = st_rdwait ? DM_out : rdata_q;
        DM_enable   = st_issue;
        DM_read     = st_issue & ~we_q;
        DM_write    = st_issue &  we_q;
        DM_address  = st_issue ? (addr_q >> WORD_SHIFT) : '0;
        DM_in       = st_issue ? wdata_q : '0;
        dbg_state_o = state_q;
    end

endmodule
